store_rmw_unit: RTL
===================

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of Address and Mem_addr.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Req_valid  input  1  pipeline presents a store request.
REQ-005 SHALL have port Req_ready  output  1  unit idle, request accepted this cycle if Req_valid=1.
REQ-006 SHALL have port Store_Select  input  1  0 = word store, 1 = byte store.
REQ-007 SHALL have port Address  input  ADDR_W  byte address; Offset = Address[1:0].
REQ-008 SHALL have port Write_data  input  32  register source value.
REQ-009 SHALL have port Busy  output  1  request in progress (not IDLE).
REQ-010 SHALL have port Done  output  1  one-cycle pulse on store completion.
REQ-011 SHALL have port Mem_addr  output  ADDR_W  word-aligned address, bits [1:0] always 0.
REQ-012 SHALL have ports Mem_rd / Mem_wr  output  1 each  memory read / write strobes.
REQ-013 SHALL have port Mem_wdata  output  32  word written to memory.
REQ-014 SHALL have port Mem_rdata  input  32  word returned by memory, valid with Mem_ack during read.
REQ-015 SHALL have port Mem_ack  input  1  memory completes current read or write.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE; Req_ready=1 only in IDLE.
REQ-017 SHALL latch Store_Select, Address, Write_data on Req_valid&&Req_ready; later input changes ignored.
REQ-018 Word store SHALL go IDLE->WRITE with Mem_wdata=Write_data; Address[1:0] ignored.
REQ-019 Byte store SHALL go IDLE->READ, hold Mem_rd=1 until Mem_ack, capture Mem_rdata on ack, go WRITE.
REQ-020 In WRITE SHALL drive Mem_wdata = captured word with lane Offset replaced by Write_data[7:0] (lane 0 = bits 7:0 ... lane 3 = bits 31:24), other lanes unchanged.
REQ-021 Mem_rd/Mem_wr/Mem_addr/Mem_wdata SHALL be registered and stable until Mem_ack; Mem_rd and Mem_wr never both 1.
REQ-022 WRITE SHALL hold Mem_wr=1 until Mem_ack, then go DONE; DONE SHALL assert Done=1 for exactly one cycle, return to IDLE.
REQ-023 Latency with zero-wait memory: word store Done 2 cycles after accept; byte store 3 cycles.
REQ-024 Mem_ack in IDLE or DONE SHALL be ignored; Mem_ack held high SHALL not advance more than one state per cycle.
REQ-025 Req_valid during Busy SHALL not be accepted and SHALL not disturb the active store.

Reset
REQ-026 rst=1 SHALL force IDLE immediately; Req_ready=1, Busy=0, Done=0, Mem_rd=0, Mem_wr=0, Mem_addr=0, Mem_wdata=0.
REQ-027 rst mid-operation SHALL abort with no further memory strobe; partial store is discarded, no Done.

Configuration
REQ-028 With STORE_HALFWORD_EN defined, SHALL add input Store_Half (1 bit); Store_Select=1 && Store_Half=1 stores Write_data[15:0] into half Address[1] via READ/WRITE, Address[0] ignored.
REQ-029 Without STORE_HALFWORD_EN, Store_Half SHALL not exist and Store_Select=1 always means byte.

Structure
REQ-030 Shared package riscv_mem_pkg SHALL hold FSM state encoding, store-size codes, lane-width constants.
REQ-031 Lane merge SHALL be a combinational sub-module store_merge (inputs old word, data, offset, size; output merged word).

Verification
REQ-032 Word store Address=0x100, Write_data=0xDEADBEEF, ack immediate -> Mem_wr=1, Mem_addr=0x100, Mem_wdata=0xDEADBEEF, Done 2 cycles after accept.
REQ-033 Byte store Address=0x102, Write_data=0x000000AA, Mem_rdata=0x11223344 -> Mem_rd then Mem_wr, Mem_addr=0x100, Mem_wdata=0x11AA3344.
REQ-034 Byte store offsets 0..3 with Mem_rdata=0xFFFFFFFF, Write_data=0x12345600 -> lane written 0x00, other lanes 0xFF.
REQ-035 Mem_ack delayed 3 cycles in READ and WRITE, Req_valid toggled while Busy -> strobes/address/data stable, no new accept, single Done.
REQ-036 rst asserted in WRITE -> next cycle Mem_wr=0, Req_ready=1, no Done; subsequent word store completes normally.
REQ-037 With STORE_HALFWORD_EN, half store Address=0x202, Write_data=0xBEEF, Mem_rdata=0x11223344 -> Mem_wdata=0xBEEF3344.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared FSM state encoding, store-size codes and lane widths
//               for the store read-modify-write path.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int c_LANE_W    = 8;
    localparam int c_HALF_W    = 16;
    localparam int c_NUM_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } rmw_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } store_size_t;

    function automatic store_size_t decode_size(input logic sel, input logic half);
        if (!sel)
            return SIZE_WORD;
        return half ? SIZE_HALF : SIZE_BYTE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge.sv
`default_nettype none
// ============================================================================
// Module      : store_merge
// Description : Combinational lane merge of store data into an existing word.
// Revision    : 1.0 - initial release
// ============================================================================
module store_merge
    import riscv_mem_pkg::*;
(
    input  logic [31:0]  i_old_word,
    input  logic [31:0]  i_data,
    input  logic [1:0]   i_offset,
    input  store_size_t  i_size,
    output logic [31:0]  o_merged
);

    always_comb begin
        o_merged = i_old_word;
        case (i_size)
            SIZE_BYTE: o_merged[{i_offset, 3'b000} +: c_LANE_W] = i_data[c_LANE_W-1:0];
            SIZE_HALF: o_merged[{i_offset[1], 4'b0000} +: c_HALF_W] = i_data[c_HALF_W-1:0];
            default:   o_merged = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_rmw_unit
// Description : Word/byte store unit; sub-word stores use read-modify-write.
//               Define STORE_HALFWORD_EN to add the Store_Half input.
// Revision    : 1.0 - initial release
// ============================================================================
module store_rmw_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Store_Select,
`ifdef STORE_HALFWORD_EN
    input  logic              Store_Half,
`endif
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       Write_data,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_rd,
    output logic              Mem_wr,
    output logic [31:0]       Mem_wdata,
    input  logic [31:0]       Mem_rdata,
    input  logic              Mem_ack
);

    rmw_state_t        r_state;
    store_size_t       r_size;
    logic [1:0]        r_offset;
    logic [31:0]       r_data;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    store_size_t       w_req_size;
    logic [31:0]       w_merged;

`ifdef STORE_HALFWORD_EN
    assign w_req_size = decode_size(Store_Select, Store_Half);
`else
    assign w_req_size = decode_size(Store_Select, 1'b0);
`endif

    // Merge operates on the word being returned, so it lands in Mem_wdata on the ack edge
    store_merge u_merge (
        .i_old_word (Mem_rdata),
        .i_data     (r_data),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_size      <= SIZE_WORD;
            r_offset    <= 2'b00;
            r_data      <= 32'd0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Req_valid) begin
                        r_size      <= w_req_size;
                        r_offset    <= Address[1:0];
                        r_data      <= Write_data;
                        r_mem_addr  <= {Address[ADDR_W-1:2], 2'b00};
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_req_size == SIZE_WORD) begin
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= Write_data;
                            r_state     <= S_WRITE;
                        end else begin
                            r_mem_rd <= 1'b1;
                            r_state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (Mem_ack) begin
                        r_mem_rd    <= 1'b0;
                        r_mem_wr    <= 1'b1;
                        r_mem_wdata <= w_merged;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (Mem_ack) begin
                        r_mem_wr <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign Req_ready = r_req_ready;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Mem_rd    = r_mem_rd;
    assign Mem_wr    = r_mem_wr;
    assign Mem_addr  = r_mem_addr;
    assign Mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
